// File: rtl/alu_issue_stage.sv
// Issue stage around a combinational ALU: request register S1, in-order result FIFO, tagged responses.
// Optional saturating statistics counters are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_stage #(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [5:0]        req_op_i,
  input  logic [DATA_W-1:0] req_a_i,
  input  logic [DATA_W-1:0] req_b_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic [5:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_out_i,
`ifdef ALU_ISSUE_STATS_EN
  output logic [15:0]       stat_issued_o,
  output logic [15:0]       stat_illegal_o,
`endif
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic              rsp_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DepthC = (CNT_W + 1)'(FIFO_DEPTH);

  logic              s1Valid_q, s1Valid_d;
  logic [5:0]        s1Op_q, s1Op_d;
  logic [DATA_W-1:0] s1A_q, s1A_d;
  logic [DATA_W-1:0] s1B_q, s1B_d;
  logic [TAG_W-1:0]  s1Tag_q, s1Tag_d;
  logic              s1Err_q, s1Err_d;

  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] memData [FIFO_DEPTH];
  logic [TAG_W-1:0]  memTag  [FIFO_DEPTH];
  logic              memErr  [FIFO_DEPTH];

  logic              reqFire;
  logic              reqIllegal;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    occupancy;

  // Credit counts the op sitting in S1 so its capture always finds a free slot.
  assign occupancy   = {1'b0, count_q} + (CNT_W + 1)'(s1Valid_q);
  assign req_ready_o = rst_ni && !flush_i && (occupancy < DepthC);
  assign reqFire     = req_valid_i && req_ready_o;
  assign reqIllegal  = req_op_i > 6'd12;

  assign push = s1Valid_q && !flush_i;
  assign pop  = rsp_valid_o && rsp_ready_i && !flush_i;

  always_comb begin
    s1Valid_d = reqFire;
    s1Op_d    = s1Op_q;
    s1A_d     = s1A_q;
    s1B_d     = s1B_q;
    s1Tag_d   = s1Tag_q;
    s1Err_d   = s1Err_q;
    if (reqFire) begin
      s1Op_d  = reqIllegal ? 6'd0 : req_op_i;
      s1A_d   = reqIllegal ? '0 : req_a_i;
      s1B_d   = reqIllegal ? '0 : req_b_i;
      s1Tag_d = req_tag_i;
      s1Err_d = reqIllegal;
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1Valid_q <= 1'b0;
      s1Op_q    <= '0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1Tag_q   <= '0;
      s1Err_q   <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Op_q    <= s1Op_d;
      s1A_q     <= s1A_d;
      s1B_q     <= s1B_d;
      s1Tag_q   <= s1Tag_d;
      s1Err_q   <= s1Err_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; the head is masked by rsp_valid_o when empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      memData[wrPtr_q] <= s1Err_q ? '0 : alu_out_i;
      memTag[wrPtr_q]  <= s1Tag_q;
      memErr[wrPtr_q]  <= s1Err_q;
    end
  end

  assign alu_op_o    = s1Op_q;
  assign alu_a_o     = s1A_q;
  assign alu_b_o     = s1B_q;
  assign rsp_valid_o = (count_q != '0);
  assign rsp_data_o  = rsp_valid_o ? memData[rdPtr_q] : '0;
  assign rsp_tag_o   = rsp_valid_o ? memTag[rdPtr_q] : '0;
  assign rsp_err_o   = rsp_valid_o ? memErr[rdPtr_q] : 1'b0;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_q;
  logic [15:0] illegal_q;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q  <= '0;
      illegal_q <= '0;
    end else if (reqFire) begin
      if (issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      if (reqIllegal && illegal_q != 16'hFFFF) illegal_q <= illegal_q + 16'd1;
    end
  end

  assign stat_issued_o  = issued_q;
  assign stat_illegal_o = illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed vectors push expected results, a monitor pops on each response.
// A behavioural ALU closes the loop from alu_*_o back to alu_out_i.
module tb_alu_issue_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [5:0]  req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic [4:0]  req_tag_i;
  logic [5:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [31:0] alu_out_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_tag_o;
  logic        rsp_err_o;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_issued_o;
  logic [15:0] stat_illegal_o;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } rsp_t;

  rsp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  alu_issue_stage #(.DATA_W(32), .TAG_W(5), .FIFO_DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_tag_i   (req_tag_i),
    .alu_op_o    (alu_op_o),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_out_i   (alu_out_i),
`ifdef ALU_ISSUE_STATS_EN
    .stat_issued_o  (stat_issued_o),
    .stat_illegal_o (stat_illegal_o),
`endif
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_tag_o   (rsp_tag_o),
    .rsp_err_o   (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural ALU standing in for the real combinational datapath.
  always_comb begin
    alu_out_i = '0;
    case (alu_op_o)
      6'd0:  alu_out_i = alu_a_o + alu_b_o;
      6'd1:  alu_out_i = alu_a_o - alu_b_o;
      6'd2:  alu_out_i = alu_a_o & alu_b_o;
      6'd3:  alu_out_i = alu_a_o ^ alu_b_o;
      6'd4:  alu_out_i = alu_a_o | alu_b_o;
      6'd5:  alu_out_i = alu_a_o << alu_b_o[4:0];
      6'd6:  alu_out_i = alu_a_o >> alu_b_o[4:0];
      6'd7:  alu_out_i = $signed(alu_a_o) >>> alu_b_o[4:0];
      6'd8:  alu_out_i = 32'(alu_a_o == alu_b_o);
      6'd9:  alu_out_i = 32'($signed(alu_a_o) > $signed(alu_b_o));
      6'd10: alu_out_i = 32'($signed(alu_a_o) < $signed(alu_b_o));
      6'd11: alu_out_i = 32'(alu_a_o != alu_b_o);
      6'd12: alu_out_i = 32'(alu_a_o > alu_b_o);
      default: alu_out_i = '0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Response monitor: a pop happens at the next rising edge when valid, ready and no flush.
  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o && rsp_ready_i && !flush_i) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_rsp: got data %h tag %0d err %0d with empty scoreboard",
                 rsp_data_o, rsp_tag_o, rsp_err_o);
      end else begin
        rsp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_data", rsp_data_o, e.data);
        checkOutput("rsp_tag", 32'(rsp_tag_o), 32'(e.tag));
        checkOutput("rsp_err", 32'(rsp_err_o), 32'(e.err));
      end
    end
  end

  // Drives a request and waits (bounded) until it is accepted; req_valid_i stays high on return.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag, input logic [31:0] expData, input logic expErr);
    bit accepted = 1'b0;
    int n = 0;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_tag_i   = tag;
    while (!accepted && n < 200) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        expQ.push_back('{data: expData, tag: tag, err: expErr});
        accepted = 1'b1;
      end
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!accepted) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL accept_timeout: got no acceptance expected acceptance of op %0d tag %0d", op, tag);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (expQ.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL drain_timeout: got %0d pending responses expected 0", expQ.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    req_tag_i   = '0;
    rsp_ready_i = 1'b1;
    #23;
    checkOutput("reset_req_ready", 32'(req_ready_o), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("reset_alu_op", 32'(alu_op_o), 32'd0);
    checkOutput("reset_alu_a", alu_a_o, 32'd0);
    checkOutput("reset_rsp_data", rsp_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // ADD latency: ALU inputs in cycle 1, response in cycle 2.
    applyStimulus(6'd0, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0);
    req_valid_i = 1'b0;
    checkOutput("t1_alu_op", 32'(alu_op_o), 32'd0);
    checkOutput("t1_alu_a", alu_a_o, 32'd5);
    checkOutput("t1_alu_b", alu_b_o, 32'd7);
    checkOutput("t1_rsp_valid_early", 32'(rsp_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput("t1_rsp_valid", 32'(rsp_valid_o), 32'd1);
    drain();

    // Back-to-back SUB then SRA, responses on consecutive cycles.
    applyStimulus(6'd1, 32'd3, 32'd5, 5'd1, 32'hFFFF_FFFE, 1'b0);
    applyStimulus(6'd7, 32'h8000_0000, 32'd4, 5'd2, 32'hF800_0000, 1'b0);
    req_valid_i = 1'b0;
    checkOutput("t2_first_data", rsp_data_o, 32'hFFFF_FFFE);
    @(posedge clk_i);
    #1;
    checkOutput("t2_second_data", rsp_data_o, 32'hF800_0000);
    drain();

    // A few more units streamed at full rate.
    applyStimulus(6'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd4, 32'h00F0_1234, 1'b0);
    applyStimulus(6'd3, 32'hAAAA_5555, 32'hFFFF_0000, 5'd5, 32'h5555_5555, 1'b0);
    applyStimulus(6'd4, 32'h0000_00F0, 32'h0F00_000F, 5'd6, 32'h0F00_00FF, 1'b0);
    applyStimulus(6'd5, 32'h0000_0003, 32'd4, 5'd7, 32'h0000_0030, 1'b0);
    applyStimulus(6'd6, 32'h8000_0000, 32'd31, 5'd8, 32'h0000_0001, 1'b0);
    applyStimulus(6'd11, 32'd7, 32'd7, 5'd9, 32'd0, 1'b0);
    req_valid_i = 1'b0;
    drain();

    // Backpressure: only four requests fit (three in FIFO plus one in S1).
    rsp_ready_i = 1'b0;
    applyStimulus(6'd0, 32'd100, 32'd1, 5'd10, 32'd101, 1'b0);
    applyStimulus(6'd0, 32'd200, 32'd2, 5'd11, 32'd202, 1'b0);
    applyStimulus(6'd0, 32'd300, 32'd3, 5'd12, 32'd303, 1'b0);
    applyStimulus(6'd0, 32'd400, 32'd4, 5'd13, 32'd404, 1'b0);
    req_op_i  = 6'd0;
    req_a_i   = 32'd500;
    req_b_i   = 32'd5;
    req_tag_i = 5'd14;
    checkOutput("t3_ready_after4", 32'(req_ready_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #1;
      checkOutput("t3_ready_full", 32'(req_ready_o), 32'd0);
      checkOutput("t3_head_held", rsp_data_o, 32'd101);
    end
    rsp_ready_i = 1'b1;
    applyStimulus(6'd0, 32'd500, 32'd5, 5'd14, 32'd505, 1'b0);
    applyStimulus(6'd0, 32'd600, 32'd6, 5'd15, 32'd606, 1'b0);
    req_valid_i = 1'b0;
    drain();

    // Illegal opcode is zeroed in S1 and returned with err set.
    applyStimulus(6'd13, 32'd9, 32'd9, 5'd21, 32'd0, 1'b1);
    req_valid_i = 1'b0;
    checkOutput("t4_alu_op", 32'(alu_op_o), 32'd0);
    checkOutput("t4_alu_a", alu_a_o, 32'd0);
    checkOutput("t4_alu_b", alu_b_o, 32'd0);
    drain();

    // Flush with three in FIFO and one in S1, concurrent request refused.
    rsp_ready_i = 1'b0;
    applyStimulus(6'd0, 32'd1, 32'd1, 5'd1, 32'd2, 1'b0);
    applyStimulus(6'd0, 32'd2, 32'd2, 5'd2, 32'd4, 1'b0);
    applyStimulus(6'd0, 32'd3, 32'd3, 5'd3, 32'd6, 1'b0);
    applyStimulus(6'd0, 32'd4, 32'd4, 5'd4, 32'd8, 1'b0);
    flush_i   = 1'b1;
    req_op_i  = 6'd0;
    req_a_i   = 32'd77;
    req_b_i   = 32'd77;
    req_tag_i = 5'd30;
    #1;
    checkOutput("t5_ready_in_flush", 32'(req_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    expQ.delete();
    checkOutput("t5_rsp_valid_after", 32'(rsp_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput("t5_rsp_valid_later", 32'(rsp_valid_o), 32'd0);
    rsp_ready_i = 1'b1;
    applyStimulus(6'd8, 32'd1, 32'd1, 5'd9, 32'd1, 1'b0);
    req_valid_i = 1'b0;
    drain();

    // Asynchronous reset in the middle of a burst.
    applyStimulus(6'd0, 32'd10, 32'd1, 5'd1, 32'd11, 1'b0);
    applyStimulus(6'd0, 32'd20, 32'd2, 5'd2, 32'd22, 1'b0);
    applyStimulus(6'd0, 32'd30, 32'd3, 5'd3, 32'd33, 1'b0);
    checkOutput("t6_valid_before_rst", 32'(rsp_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_rsp_valid_rst", 32'(rsp_valid_o), 32'd0);
    checkOutput("t6_alu_a_rst", alu_a_o, 32'd0);
    checkOutput("t6_ready_rst", 32'(req_ready_o), 32'd0);
    expQ.delete();
    req_valid_i = 1'b0;
`ifdef ALU_ISSUE_STATS_EN
    checkOutput("t6_stat_issued_rst", 32'(stat_issued_o), 32'd0);
    checkOutput("t6_stat_illegal_rst", 32'(stat_illegal_o), 32'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    applyStimulus(6'd0, 32'd40, 32'd2, 5'd17, 32'd42, 1'b0);
    req_valid_i = 1'b0;
    checkOutput("t6_rsp_valid_early", 32'(rsp_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput("t6_rsp_valid_lat2", 32'(rsp_valid_o), 32'd1);
    drain();
`ifdef ALU_ISSUE_STATS_EN
    checkOutput("t6_stat_issued", 32'(stat_issued_o), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
